// File: rtl/pvar_pkg.sv
// Shared types and helpers for the channel step machine: opcode and run-state
// encodings plus the tag-width rule used by every file of the block.
package pvar_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_SWAP  = 2'd2,
        OP_HALT  = 2'd3
    } op_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } run_state_t;

    // A tag is always at least one bit wide, even with two channels.
    function automatic int tag_width(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/pvar_chan_step_if.sv
// Bus bundle for pvar_chan_step: input word, registered result and status.
// __in_valid qualifies __in0 in the same cycle; there is no ready, the block
// takes every valid word while it is in RUN and drops words while in HALT.
interface pvar_chan_step_if #(
    parameter int W  = 8,
    parameter int TW = 2
);
    import pvar_pkg::*;

    logic              __in_valid;
    logic [2+TW+W-1:0] __in0;
    logic              __out_valid;
    logic [W-1:0]      __out0;
    logic [TW-1:0]     __out_tag;
    logic              __err;
    logic              __continue;
    logic [31:0]       __steps;
    run_state_t        dbg_state;

    modport master (
        output __in_valid, __in0,
        input  __out_valid, __out0, __out_tag, __err, __continue, __steps, dbg_state
    );

    modport slave (
        input  __in_valid, __in0,
        output __out_valid, __out0, __out_tag, __err, __continue, __steps, dbg_state
    );

endinterface

// File: rtl/pvar_chan_regfile.sv
// CHANNELS x W channel registers with a tag read port, a neighbour read port
// and two write ports so a SWAP lands both halves in one cycle.
module pvar_chan_regfile #(
    parameter int           W        = 8,
    parameter int           CHANNELS = 4,
    parameter int           TW       = 2,
    parameter logic [W-1:0] INIT     = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] rd_tag,
    output logic [W-1:0]  rd_data,
    input  logic [TW-1:0] nb_tag,
    output logic [W-1:0]  nb_data,
    input  logic          we_a,
    input  logic [TW-1:0] wa_tag,
    input  logic [W-1:0]  wa_data,
    input  logic          we_b,
    input  logic [TW-1:0] wb_tag,
    input  logic [W-1:0]  wb_data
);

    logic [W-1:0] st_q [CHANNELS];
    logic [W-1:0] st_d [CHANNELS];

    always_comb begin
        st_d = st_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (we_a && wa_tag == TW'(i)) st_d[i] = wa_data;
            if (we_b && wb_tag == TW'(i)) st_d[i] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) st_q[i] <= INIT;
        end else begin
            st_q <= st_d;
        end
    end

    // Tags past the last channel read as zero rather than aliasing a channel.
    always_comb begin
        rd_data = '0;
        nb_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_tag == TW'(i)) rd_data = st_q[i];
            if (nb_tag == TW'(i)) nb_data = st_q[i];
        end
    end

endmodule

// File: rtl/pvar_chan_step.sv
// Resumption-style step machine over CHANNELS W-bit registers: one registered
// result per accepted word, RUN/HALT control and a saturating step counter.
module pvar_chan_step
    import pvar_pkg::*;
#(
    parameter int           W         = 8,
    parameter int           CHANNELS  = 4,
    parameter int           MAX_STEPS = 0,
    parameter logic [W-1:0] INIT      = '0
) (
    input logic              clk,
    input logic              rst,
    pvar_chan_step_if.slave  bus
);

    localparam int TW = tag_width(CHANNELS);

    op_t           op;
    logic [TW-1:0] tag;
    logic [W-1:0]  pay;
    logic          accept;
    logic          tag_ok;
    logic [TW:0]   tag_inc;
    logic [TW-1:0] nb_tag;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  nb_data;
    logic          we_a;
    logic          we_b;
    logic [W-1:0]  wa_data;
    logic [31:0]   steps_inc;
    logic          limit_hit;

    run_state_t    state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out0_q, out0_d;
    logic [TW-1:0] out_tag_q, out_tag_d;
    logic          err_q, err_d;
    logic [31:0]   steps_q, steps_d;

    assign op  = op_t'(bus.__in0[W+TW +: 2]);
    assign tag = bus.__in0[W +: TW];
    assign pay = bus.__in0[W-1:0];

    assign accept  = (state_q == RUN) && bus.__in_valid;
    assign tag_ok  = 32'(tag) < 32'(CHANNELS);
    assign tag_inc = (TW+1)'(tag) + (TW+1)'(1);
    // Neighbour wraps from the last channel back to channel 0.
    assign nb_tag  = (tag_inc == (TW+1)'(CHANNELS)) ? '0 : tag_inc[TW-1:0];

    assign we_a    = accept && tag_ok && (op == OP_WRITE || op == OP_SWAP);
    assign we_b    = accept && tag_ok && (op == OP_SWAP);
    assign wa_data = (op == OP_SWAP) ? nb_data : pay;

    pvar_chan_regfile #(
        .W        (W),
        .CHANNELS (CHANNELS),
        .TW       (TW),
        .INIT     (INIT)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rd_tag  (tag),
        .rd_data (rd_data),
        .nb_tag  (nb_tag),
        .nb_data (nb_data),
        .we_a    (we_a),
        .wa_tag  (tag),
        .wa_data (wa_data),
        .we_b    (we_b),
        .wb_tag  (nb_tag),
        .wb_data (rd_data)
    );

    assign steps_inc = (steps_q == '1) ? steps_q : steps_q + 32'd1;
    assign limit_hit = (MAX_STEPS != 0) && (steps_inc == 32'(MAX_STEPS));

    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept && (op == OP_HALT || limit_hit)) state_d = HALT;
    end

    always_comb begin
        out_valid_d = 1'b0;
        out0_d      = out0_q;
        out_tag_d   = out_tag_q;
        err_d       = err_q;
        steps_d     = steps_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_tag_d   = tag;
            steps_d     = steps_inc;
            if (op == OP_HALT) begin
                out0_d = pay;
                err_d  = 1'b0;
            end else if (!tag_ok) begin
                out0_d = '0;
                err_d  = 1'b1;
            end else begin
                out0_d = rd_data;
                err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out_tag_q   <= '0;
            err_q       <= 1'b0;
            steps_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out0_q      <= out0_d;
            out_tag_q   <= out_tag_d;
            err_q       <= err_d;
            steps_q     <= steps_d;
        end
    end

    assign bus.__out_valid = out_valid_q;
    assign bus.__out0      = out0_q;
    assign bus.__out_tag   = out_tag_q;
    assign bus.__err       = err_q;
    assign bus.__steps     = steps_q;
    assign bus.__continue  = (state_q == RUN);
    assign bus.dbg_state   = state_q;

endmodule
